// File: rtl/commit_trace_buffer.sv
// Captures (seq, pc, inst) on each pc change into a FWFT circular FIFO; entry visible 1 cycle after capture.
// Valid/ready drain; a capture into a full FIFO with no pop is dropped and counted in overflow_cnt.
module commit_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       inst_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_seq,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic [15:0]       overflow_cnt
);

  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [31:0]       pc_prev;
  logic [31:0]       seq;
  logic              cap;
  logic              pop;
  logic              push;
  logic              drop;

  always_comb begin
    cap  = en & (pc_i != pc_prev);
    pop  = out_valid & out_ready;
    push = cap & (~full | pop);
    drop = cap & full & ~pop;
  end

  assign out_valid = (count != '0);
  assign full      = (count == FULL_CNT);
  assign head      = mem[rd_ptr];
  assign out_seq   = head.seq;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;

  // seq advances on dropped captures too, so gaps in out_seq reveal losses
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_prev      <= '0;
      seq          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= '0;
    end else begin
      pc_prev <= pc_i;
      if (cap)
        seq <= seq + 32'd1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (drop && (overflow_cnt != 16'hFFFF))
        overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  // Payload storage needs no reset; only the bookkeeping above defines validity
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{seq: seq, pc: pc_i, inst: inst_i};
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_seq;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [4:0]  count;
  logic        full;
  logic [15:0] overflow_cnt;

  int total = 0;
  int bad   = 0;

  logic [95:0] sb [$];
  logic [31:0] m_pc_prev;
  logic [31:0] m_seq;
  int          m_count;
  logic [15:0] m_ovf;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .en(en), .pc_i(pc_i), .inst_i(inst_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq),
    .out_pc(out_pc), .out_inst(out_inst), .count(count), .full(full),
    .overflow_cnt(overflow_cnt)
  );

  // Scoreboard consumer: every accepted head must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_pop: got seq=%0d pc=%h inst=%h, required no entry", out_seq, out_pc, out_inst);
      end else begin
        if ({out_seq, out_pc, out_inst} !== sb[0]) begin
          bad++;
          $display("FAIL sb_entry: got seq=%0d pc=%h inst=%h, required seq=%0d pc=%h inst=%h",
                   out_seq, out_pc, out_inst, sb[0][95:64], sb[0][63:32], sb[0][31:0]);
        end
        void'(sb.pop_front());
      end
    end
  end

  // Reference model advance for the edge about to occur, then move past that edge
  task automatic step();
    int pop_m, cap_m, push_m;
    bit full_m;
    if (reset) begin
      m_pc_prev = '0;
      m_seq     = '0;
      m_count   = 0;
      m_ovf     = '0;
      sb.delete();
    end else begin
      pop_m  = (m_count != 0 && out_ready) ? 1 : 0;
      cap_m  = (en && pc_i != m_pc_prev) ? 1 : 0;
      full_m = (m_count == 16);
      push_m = (cap_m == 1 && (!full_m || pop_m == 1)) ? 1 : 0;
      if (push_m == 1) sb.push_back({m_seq, pc_i, inst_i});
      if (cap_m == 1 && full_m && pop_m == 0 && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
      if (cap_m == 1) m_seq = m_seq + 32'd1;
      m_count   = m_count + push_m - pop_m;
      m_pc_prev = pc_i;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; pc_i = '0; inst_i = '0; out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d required 0", count); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b required 0", full); end
    total++; if (overflow_cnt !== 16'd0) begin bad++; $display("FAIL reset_ovf: got %0d required 0", overflow_cnt); end
    for (int i = 0; i < 10; i++) step();
    total++; if (out_valid !== 1'b0 || count !== 5'd0) begin
      bad++; $display("FAIL pc_zero_hold: got valid=%b count=%0d required 0/0", out_valid, count);
    end
  endtask

  task automatic test_basic();
    logic [31:0] pcs [3];
    logic [31:0] insts [3];
    pcs   = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008};
    insts = '{32'h2001_0001, 32'h2002_0002, 32'h0022_1820};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_i = pcs[i]; inst_i = insts[i];
      step();
      total++;
      if (out_valid !== 1'b1 || out_seq !== 32'(i) || out_pc !== pcs[i] || out_inst !== insts[i]) begin
        bad++;
        $display("FAIL basic_entry%0d: got v=%b seq=%0d pc=%h inst=%h required v=1 seq=%0d pc=%h inst=%h",
                 i, out_valid, out_seq, out_pc, out_inst, i, pcs[i], insts[i]);
      end
      step();
    end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL basic_drained: got count=%0d required 0", count); end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pc_i = 32'h0050_0000 + 32'(4 * i); inst_i = 32'(i);
      step();
      if (i == 15) begin
        total++; if (full !== 1'b1 || count !== 5'd16) begin
          bad++; $display("FAIL fill16: got full=%b count=%0d required 1/16", full, count);
        end
      end
    end
    total++; if (overflow_cnt !== 16'd4 || count !== 5'd16) begin
      bad++; $display("FAIL overflow: got ovf=%0d count=%0d required 4/16", overflow_cnt, count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (out_seq !== 32'(i)) begin bad++; $display("FAIL drain_seq: got %0d required %0d", out_seq, i); end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got valid=%b required 0", out_valid); end
    out_ready = 1'b0;
    pc_i = 32'h0060_0000; inst_i = 32'h1111_0000;
    step();
    total++; if (out_seq !== 32'd20) begin bad++; $display("FAIL seq_gap: got %0d required 20", out_seq); end
  endtask

  task automatic test_full_pop();
    for (int i = 1; i < 16; i++) begin
      pc_i = 32'h0060_0000 + 32'(4 * i); inst_i = 32'h1111_0000 + 32'(i);
      step();
    end
    total++; if (count !== 5'd16 || full !== 1'b1) begin
      bad++; $display("FAIL refill: got count=%0d full=%b required 16/1", count, full);
    end
    out_ready = 1'b1;
    pc_i = 32'h0060_0100; inst_i = 32'h2222_0000;
    step();
    total++; if (count !== 5'd16 || full !== 1'b1 || overflow_cnt !== 16'd4) begin
      bad++; $display("FAIL full_pop_push: got count=%0d full=%b ovf=%0d required 16/1/4", count, full, overflow_cnt);
    end
    total++; if (out_seq !== 32'd21) begin bad++; $display("FAIL full_pop_head: got %0d required 21", out_seq); end
    for (int i = 0; i < 16; i++) step();
    total++; if (count !== 5'd0) begin bad++; $display("FAIL full_pop_drain: got count=%0d required 0", count); end
  endtask

  task automatic test_enable();
    out_ready = 1'b0;
    pc_i = 32'h0040_0010; inst_i = 32'h3333_0010;
    step();
    en = 1'b0; pc_i = 32'h0040_0014; inst_i = 32'h3333_0014;
    step();
    en = 1'b1;
    step();
    step();
    total++; if (count !== 5'd1) begin bad++; $display("FAIL en_gate: got count=%0d required 1", count); end
    pc_i = 32'h0040_0018; inst_i = 32'h3333_0018;
    step();
    total++; if (count !== 5'd2 || out_seq !== 32'd37) begin
      bad++; $display("FAIL en_next: got count=%0d head_seq=%0d required 2/37", count, out_seq);
    end
    out_ready = 1'b1;
    step();
    total++; if (out_seq !== 32'd38 || out_pc !== 32'h0040_0018) begin
      bad++; $display("FAIL en_seq: got seq=%0d pc=%h required 38/00400018", out_seq, out_pc);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pc_i = 32'h0070_0000 + 32'(4 * i); inst_i = 32'h4444_0000 + 32'(i);
      step();
    end
    total++; if (count !== 5'd5) begin bad++; $display("FAIL mid_fill: got count=%0d required 5", count); end
    out_ready = 1'b1;
    do_reset();
    total++; if (count !== 5'd0 || out_valid !== 1'b0 || overflow_cnt !== 16'd0) begin
      bad++; $display("FAIL mid_reset: got count=%0d valid=%b ovf=%0d required 0/0/0", count, out_valid, overflow_cnt);
    end
    out_ready = 1'b0;
    pc_i = 32'h0080_0000; inst_i = 32'h5555_0000;
    step();
    total++; if (out_valid !== 1'b1 || out_seq !== 32'd0) begin
      bad++; $display("FAIL mid_seq0: got valid=%b seq=%0d required 1/0", out_valid, out_seq);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    int odd_count = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pc_i = 32'h0090_0000 + 32'(4 * i); inst_i = 32'h6666_0000 + 32'(i);
      step();
      if (count !== 5'd1) odd_count++;
    end
    total++; if (odd_count != 0) begin bad++; $display("FAIL b2b_count: got %0d cycles with count!=1 required 0", odd_count); end
    total++; if (overflow_cnt !== 16'd0) begin bad++; $display("FAIL b2b_ovf: got %0d required 0", overflow_cnt); end
    step();
    total++; if (count !== 5'd0 || sb.size() != 0) begin
      bad++; $display("FAIL b2b_drain: got count=%0d pending=%0d required 0/0", count, sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Hardware retire-trace capture stage that sits directly downstream of `sccomp_dataflow`, consuming its `pc`/`inst` outputs. Detects each program-counter change, which marks a new instruction in the multi-cycle CPU, and records the (sequence number, pc, inst) triple into a circular FIFO. The FIFO drains through a valid/ready port to a UART or trace sink, so the per-instruction trace normally produced by simulation can be collected on the board. Overflow is counted, never silently lost.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `ADDR_W`, 4: log2(`DEPTH`).
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  capture enable; when low, nothing is captured and `pc_prev` still tracks `pc_i`.
- `pc_i`  in  32  CPU program counter (`sccomp_dataflow` `pc`).
- `inst_i`  in  32  instruction at `pc_i` (`sccomp_dataflow` `inst`).
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  sink accepts head this cycle.
- `out_seq`  out  32  sequence number of head entry.
- `out_pc`  out  32  pc of head entry.
- `out_inst`  out  32  inst of head entry.
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `overflow_cnt`  out  16  dropped captures; saturates at 16'hFFFF.

## Operation
- Change detector: register `pc_prev` (reset 32'h0000_0000).
  - `cap = en & (pc_i != pc_prev)`.
  - `pc_prev <= pc_i` every cycle that `reset` is low, regardless of `en` or drop.
  - A first pc of 0 after reset is not captured. A first pc ≠0, e.g. 32'h0040_0000, is captured.
- Sequence counter `seq` (reset 0):
  - increments by 1 on every `cap`, including dropped captures, so gaps in `out_seq` expose losses;
  - wraps modulo 2^32.
- `pop = out_valid & out_ready`.
- `push = cap & (~full | pop)`.
  - When full with a simultaneous pop, the push is accepted.
- Drop: `cap & full & ~pop` → entry discarded; `overflow_cnt` increments, saturating.
- Storage: register array of DEPTH × 96 bits (seq, pc, inst).
  - Write at `wr_ptr` on push; `rd_ptr` advances on pop.
  - Pointers are ADDR_W bits and wrap DEPTH-1→0.
- `count` update:
  - +1 on push only;
  - −1 on pop only;
  - unchanged on push and pop together.
- Output is first-word-fall-through: `out_*` driven combinationally from `mem[rd_ptr]`; `out_valid = (count != 0)`.
- No state machine beyond pointer/count bookkeeping. Implicit states: EMPTY (count=0), PARTIAL, FULL (count=DEPTH).
- Reset mid-operation:
  - clears pointers, `count`, `seq`, `overflow_cnt`, `pc_prev`;
  - stored data contents are don't-care;
  - an in-flight head entry is discarded; no capture occurs in the reset cycle.

## Timing
- Reset values: `out_valid`=0, `count`=0, `full`=0, `overflow_cnt`=0. `out_seq`/`out_pc`/`out_inst` are X/don't-care while `out_valid`=0.
- Capture latency: pc change present before edge N → entry written at edge N → `out_valid`=1 after edge N (1 cycle).
- Handshake:
  - `out_*` stable while `out_valid & ~out_ready`;
  - head advances at the edge where `pop`=1;
  - `out_ready` while empty has no effect.
- Throughput: one push and one pop per cycle. A sustained pc change every cycle with `out_ready`=1 never overflows.
- `full`, `count`, and `overflow_cnt` are registered-state derived and valid the cycle after the causing edge.

## Test plan
- Reset then hold `pc_i`=0, `en`=1 for 10 cycles → `out_valid`=0, `count`=0, no captures.
- Drive pc 0x00400000, 0x00400004, 0x00400008 (2 cycles each), `inst_i`=0x20010001/0x20020002/0x00221820, `out_ready`=1 → three entries with seq 0,1,2 and the matching pc/inst, each visible one cycle after the change.
- `out_ready`=0, 20 distinct pc values, DEPTH=16 → `full`=1 after the 16th, `overflow_cnt`=4. Then drain: seq 0..15 in order; the next capture has seq 20.
- Full FIFO, pc change in the same cycle as `out_ready`=1 → push accepted, `count` stays 16, `overflow_cnt` unchanged.
- Toggle `en`=0 across a pc change 0x00400010→0x00400014, then `en`=1 with pc unchanged → no capture. The next change is captured with the next sequential seq.
- Assert `reset` for 1 cycle with `count`=5 → the next cycle has `count`=0, `out_valid`=0, `overflow_cnt`=0, and the next capture has seq 0.
